// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU with stored Z/N/C/V flags behind a valid/ready handshake.
// Define SEQ_ALU_MUL_EN to build op 11 as a WIDTH-cycle shift-add multiply; otherwise op 11 is illegal.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             ready,
   input  logic [3:0]       alu_op,
   input  logic [1:0]       ra_field,
   input  logic             dec_ra,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             z_flag,
   output logic             n_flag,
   output logic             c_flag,
   output logic             v_flag,
   output logic             flags_update,
   output logic             done
);

`ifdef SEQ_ALU_MUL_EN
   typedef enum logic [1:0] {IDLE, DONE, MUL} state_t;
`else
   typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
   logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, fu_q, fu_d;

   logic [WIDTH-1:0] alu_res, add_x, add_y;
   logic [WIDTH:0]   sum;
   logic             add_ci, use_sum, upd_zn, alu_c, alu_v, alu_z, alu_n, alu_fu, is_mul;

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y,
                                    input logic signed [WIDTH-1:0] s);
      return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
   endfunction

   // Every subtract is a + ~y + carry-in, so C out is the "no borrow" flag directly.
   always_comb begin
      alu_res = result_q;
      alu_c   = c_q;
      alu_v   = v_q;
      alu_fu  = 1'b1;
      add_x   = '0;
      add_y   = '0;
      add_ci  = 1'b0;
      use_sum = 1'b0;
      upd_zn  = 1'b0;
      case (alu_op)
         4'd1: begin alu_res = operand_b; alu_fu = 1'b0; end
         4'd2: begin add_x = operand_a; add_y = operand_b; use_sum = 1'b1; end
         4'd3: begin add_x = operand_a; add_y = ~operand_b; add_ci = 1'b1; use_sum = 1'b1; end
         4'd4: begin alu_res = operand_a & operand_b; upd_zn = 1'b1; end
         4'd5: begin alu_res = operand_a | operand_b; upd_zn = 1'b1; end
         4'd6: begin
            case (ra_field)
               2'd0: begin
                  alu_res = {operand_b[WIDTH-2:0], c_q};
                  alu_c   = operand_b[WIDTH-1];
                  alu_v   = operand_b[WIDTH-1] ^ operand_b[WIDTH-2];
                  upd_zn  = 1'b1;
               end
               2'd1: begin
                  alu_res = {c_q, operand_b[WIDTH-1:1]};
                  alu_c   = operand_b[0];
                  alu_v   = operand_b[WIDTH-1] ^ c_q;
                  upd_zn  = 1'b1;
               end
               2'd2:    alu_c = 1'b1;
               default: alu_c = 1'b0;
            endcase
         end
         4'd8: begin
            if (dec_ra) begin
               add_x = operand_a; add_y = '1; use_sum = 1'b1;
            end else begin
               case (ra_field)
                  2'd0: begin alu_res = ~operand_b; upd_zn = 1'b1; end
                  2'd1: begin alu_res = ~operand_b + WIDTH'(1); upd_zn = 1'b1; end
                  2'd2: begin add_x = operand_b; add_ci = 1'b1; use_sum = 1'b1; end
                  default: begin add_x = operand_b; add_y = '1; use_sum = 1'b1; end
               endcase
            end
         end
         4'd9:  begin add_x = operand_a; add_y = operand_b; add_ci = c_q; use_sum = 1'b1; end
         4'd10: begin add_x = operand_a; add_y = ~operand_b; add_ci = c_q; use_sum = 1'b1; end
         default: alu_fu = 1'b0;
      endcase
      sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
      if (use_sum) begin
         alu_res = sum[WIDTH-1:0];
         alu_c   = sum[WIDTH];
         alu_v   = add_ovf(add_x, add_y, sum[WIDTH-1:0]);
         upd_zn  = 1'b1;
      end
   end

   assign alu_z = upd_zn ? (alu_res == '0) : z_q;
   assign alu_n = upd_zn ? alu_res[WIDTH-1] : n_q;

`ifdef SEQ_ALU_MUL_EN
   localparam int CNT_W = $clog2(WIDTH);
   logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     mul_sum;

   // Multiplier sits in the low half of prod and is consumed LSB-first as the sum shifts in.
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
      prod_step = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
   end
   assign is_mul = (alu_op == 4'd11);
`else
   assign is_mul = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      hi_d     = hi_q;
      z_d      = z_q;
      n_d      = n_q;
      c_d      = c_q;
      v_d      = v_q;
      fu_d     = 1'b0;
`ifdef SEQ_ALU_MUL_EN
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (is_mul) begin
`ifdef SEQ_ALU_MUL_EN
                  state_d = MUL;
                  prod_d  = {{WIDTH{1'b0}}, operand_a};
                  mcand_d = operand_b;
                  cnt_d   = '0;
`endif
               end else begin
                  state_d  = DONE;
                  result_d = alu_res;
                  hi_d     = '0;
                  z_d      = alu_z;
                  n_d      = alu_n;
                  c_d      = alu_c;
                  v_d      = alu_v;
                  fu_d     = alu_fu;
               end
            end
         end
`ifdef SEQ_ALU_MUL_EN
         MUL: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d  = DONE;
               result_d = prod_step[WIDTH-1:0];
               hi_d     = prod_step[2*WIDTH-1:WIDTH];
               z_d      = (prod_step == '0);
               n_d      = prod_step[2*WIDTH-1];
               c_d      = (prod_step[2*WIDTH-1:WIDTH] != '0);
               fu_d     = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         hi_q     <= '0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         fu_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         z_q      <= z_d;
         n_q      <= n_d;
         c_q      <= c_d;
         v_q      <= v_d;
         fu_q     <= fu_d;
      end
   end

`ifdef SEQ_ALU_MUL_EN
   always_ff @(posedge clk) begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
   end
`endif

   assign ready        = (state_q == IDLE);
   assign done         = (state_q == DONE);
   assign result       = result_q;
   assign result_hi    = hi_q;
   assign z_flag       = z_q;
   assign n_flag       = n_q;
   assign c_flag       = c_q;
   assign v_flag       = v_q;
   assign flags_update = fu_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an integer-arithmetic reference model.
module tb_seq_alu;
   localparam int     W    = 8;
   localparam longint MASK = (longint'(1) << W) - 1;
   localparam longint MAXS = (longint'(1) << (W-1)) - 1;
   localparam longint MINS = -(longint'(1) << (W-1));

   logic         clk = 1'b0;
   logic         rst_n, in_valid, dec_ra;
   logic         ready, z_flag, n_flag, c_flag, v_flag, flags_update, done;
   logic [3:0]   alu_op;
   logic [1:0]   ra_field;
   logic [W-1:0] operand_a, operand_b, result, result_hi;

   int     n_checks = 0;
   int     n_errors = 0;
   longint e_res, e_hi;
   bit     e_z, e_n, e_c, e_v, e_fu;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ready(ready),
      .alu_op(alu_op), .ra_field(ra_field), .dec_ra(dec_ra),
      .operand_a(operand_a), .operand_b(operand_b),
      .result(result), .result_hi(result_hi),
      .z_flag(z_flag), .n_flag(n_flag), .c_flag(c_flag), .v_flag(v_flag),
      .flags_update(flags_update), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint sx(input longint x);
      return (x > MAXS) ? x - (MASK + 1) : x;
   endfunction

   function automatic bit ovf(input longint v);
      return (v > MAXS) || (v < MINS);
   endfunction

   task automatic m_zn();
      e_z = (e_res == 0);
      e_n = ((e_res >> (W-1)) & 1) != 0;
   endtask

   task automatic m_add(input longint x, input longint y, input longint ci);
      longint s;
      s = x + y + ci;
      e_res = s & MASK;
      e_c = ((s >> W) & 1) != 0;
      e_v = ovf(sx(x) + sx(y) + ci);
      m_zn();
   endtask

   task automatic m_sub(input longint x, input longint y, input longint bi);
      e_res = (x - y - bi) & MASK;
      e_c = (x >= y + bi);
      e_v = ovf(sx(x) - sx(y) - bi);
      m_zn();
   endtask

   task automatic m_reset();
      e_res = 0; e_hi = 0; e_z = 0; e_n = 0; e_c = 0; e_v = 0; e_fu = 0;
   endtask

   task automatic model(input int op, input int ra, input bit dec, input longint a, input longint b);
      bit     nc;
      longint p;
      e_fu = 1;
      e_hi = 0;
      case (op)
         1: begin e_res = b; e_fu = 0; end
         2: m_add(a, b, 0);
         3: m_sub(a, b, 0);
         4: begin e_res = a & b; m_zn(); end
         5: begin e_res = a | b; m_zn(); end
         6: case (ra)
               0: begin
                  nc = ((b >> (W-1)) & 1) != 0;
                  e_res = ((b << 1) | longint'(e_c)) & MASK;
                  e_v = ((((b ^ e_res) >> (W-1)) & 1) != 0);
                  e_c = nc; m_zn();
               end
               1: begin
                  nc = (b & 1) != 0;
                  e_res = (longint'(e_c) << (W-1)) | (b >> 1);
                  e_v = ((((b ^ e_res) >> (W-1)) & 1) != 0);
                  e_c = nc; m_zn();
               end
               2: e_c = 1;
               default: e_c = 0;
            endcase
         8: if (dec) m_sub(a, 1, 0);
            else case (ra)
               0: begin e_res = MASK ^ b; m_zn(); end
               1: begin e_res = (MASK + 1 - b) & MASK; m_zn(); end
               2: m_add(b, 1, 0);
               default: m_sub(b, 1, 0);
            endcase
         9:  m_add(a, b, longint'(e_c));
         10: m_sub(a, b, longint'(!e_c));
`ifdef SEQ_ALU_MUL_EN
         11: begin
            p = a * b;
            e_res = p & MASK;
            e_hi = p >> W;
            e_z = (p == 0);
            e_n = ((p >> (2*W-1)) & 1) != 0;
            e_c = (e_hi != 0);
         end
`endif
         default: e_fu = 0;
      endcase
   endtask

   task automatic do_op(input logic [3:0] op, input logic [1:0] ra, input logic dec,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      int exp_lat;
      int k;
      exp_lat = 1;
`ifdef SEQ_ALU_MUL_EN
      if (op == 4'd11) exp_lat = W + 1;
`endif
      chk("ready_idle", ready, 1'b1);
      alu_op = op; ra_field = ra; dec_ra = dec; operand_a = a; operand_b = b; in_valid = 1'b1;
      model(int'(op), int'(ra), dec, longint'(a), longint'(b));
      @(posedge clk); #1;
      // garbage request while busy must be ignored
      alu_op = 4'($urandom); operand_a = W'($urandom); operand_b = W'($urandom);
      k = 1;
      while (!done && k < 3*W) begin
         @(posedge clk); #1;
         k++;
         in_valid = 1'b0;
      end
      chk("latency", k, exp_lat);
      chk("result", result, e_res);
      chk("result_hi", result_hi, e_hi);
      chk("flags_zncv", {z_flag, n_flag, c_flag, v_flag}, {e_z, e_n, e_c, e_v});
      chk("flags_update", flags_update, e_fu);
      chk("ready_busy", ready, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("done_clear", done, 1'b0);
      chk("fu_clear", flags_update, 1'b0);
      chk("ready_back", ready, 1'b1);
      chk("result_hold", result, e_res);
      chk("flags_hold", {z_flag, n_flag, c_flag, v_flag}, {e_z, e_n, e_c, e_v});
   endtask

   initial begin
      bit saw_done;
      rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; ra_field = '0; dec_ra = 1'b0;
      operand_a = '0; operand_b = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", ready, 1'b1);
      chk("rst_result", result, 0);
      chk("rst_hi", result_hi, 0);
      chk("rst_flags", {z_flag, n_flag, c_flag, v_flag}, 4'b0000);
      chk("rst_done", done, 1'b0);
      chk("rst_fu", flags_update, 1'b0);
      rst_n = 1'b1;

      do_op(4'd2, 2'd0, 1'b0, 8'h7F, 8'h01);
      chk("plan_add", {result, n_flag, v_flag, c_flag, z_flag}, {8'h80, 4'b1100});
      do_op(4'd3, 2'd0, 1'b0, 8'h00, 8'h01);
      chk("plan_sub", {result, c_flag, n_flag, v_flag}, {8'hFF, 3'b010});
      do_op(4'd10, 2'd0, 1'b0, 8'h05, 8'h01);
      chk("plan_sbc", result, 8'h03);
      do_op(4'd6, 2'd2, 1'b0, 8'h00, 8'h00);
      do_op(4'd9, 2'd0, 1'b0, 8'hFF, 8'h00);
      chk("plan_adc", {result, z_flag, c_flag}, {8'h00, 2'b11});
      do_op(4'd6, 2'd1, 1'b0, 8'h00, 8'h02);
      chk("plan_ror", {result, c_flag}, {8'h81, 1'b0});
      do_op(4'd8, 2'd2, 1'b0, 8'h00, 8'h7F);
      chk("inc_ovf", {result, v_flag}, {8'h80, 1'b1});
      do_op(4'd8, 2'd3, 1'b0, 8'h00, 8'h80);
      chk("dec_ovf", {result, v_flag}, {8'h7F, 1'b1});
      do_op(4'd8, 2'd1, 1'b1, 8'h00, 8'h55);
      do_op(4'd3, 2'd0, 1'b0, 8'h00, 8'h01);
      do_op(4'd11, 2'd0, 1'b0, 8'h0F, 8'h11);
`ifdef SEQ_ALU_MUL_EN
      chk("plan_mul", {result, result_hi, c_flag}, {8'hFF, 8'h00, 1'b0});
`else
      chk("op11_illegal", {result, z_flag, n_flag, c_flag, v_flag}, {8'hFF, 4'b0100});
`endif
      do_op(4'd7, 2'd0, 1'b0, 8'h12, 8'h34);

`ifdef SEQ_ALU_MUL_EN
      alu_op = 4'd11; operand_a = 8'h0F; operand_b = 8'h11; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("mid_mul_busy", ready, 1'b0);
`endif
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_reset();
      chk("mrst_ready", ready, 1'b1);
      chk("mrst_out", {result, result_hi, z_flag, n_flag, c_flag, v_flag, done}, 21'd0);
      saw_done = 1'b0;
      repeat (W + 2) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      chk("mrst_no_done", saw_done, 1'b0);
      do_op(4'd2, 2'd0, 1'b0, 8'h01, 8'h01);
      chk("mrst_add", result, 8'h02);

      for (int i = 0; i < 200; i++) begin
         do_op(4'($urandom_range(0, 15)), 2'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
